// File: rtl/activity_monitor_mc.sv
// ============================================================================
// activity_monitor_mc: windowed per-channel activity averaging with a
// hysteresis alarm per channel. Optional macro ACTMON_PEAK_HOLD_EN adds peak hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

module activity_monitor_mc #(
  parameter int NUM_CH   = 4,
  parameter int ACT_W    = 16,
  parameter int LVL_W    = 8,
  parameter int WIN_LOG2 = 2,
  parameter int HI_TH    = 192,
  parameter int LO_TH    = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sample_valid,
  input  logic [NUM_CH*ACT_W-1:0]                activity,
`ifdef ACTMON_PEAK_HOLD_EN
  input  logic                                   peak_clear,
  output logic [NUM_CH*LVL_W-1:0]                peak,
`endif
  output logic [NUM_CH*LVL_W-1:0]                level,
  output logic                                   level_valid,
  output logic [NUM_CH-1:0]                      alarm,
  output logic [(WIN_LOG2 > 0 ? WIN_LOG2 : 1)-1:0] win_count
);

  localparam int CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam int ACC_W = LVL_W + WIN_LOG2;
  localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [LVL_W-1:0] HI_V    = LVL_W'(HI_TH);
  localparam logic [LVL_W-1:0] LO_V    = LVL_W'(LO_TH);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  logic win_last;
  logic win_close;
  logic unused_act;

  // Only the MSB slice of each activity word is sampled.
  assign unused_act = ^activity;
  assign win_last   = (win_count == WIN_MAX);
  assign win_close  = sample_valid && win_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_count   <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= win_close;
      if (sample_valid) begin
        win_count <= win_last ? '0 : win_count + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LVL_W-1:0] smp;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [LVL_W-1:0] avg;
    logic [LVL_W-1:0] lvl_q;
    state_t           state;
    state_t           state_nxt;

    assign smp = activity[c*ACT_W + ACT_W-1 -: LVL_W];
    assign sum = acc + ACC_W'(smp);
    // Upper LVL_W bits of the sum are the truncated window average.
    assign avg = sum[ACC_W-1 -: LVL_W];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc   <= '0;
        lvl_q <= '0;
      end else if (sample_valid) begin
        if (win_last) begin
          acc   <= '0;
          lvl_q <= avg;
        end else begin
          acc   <= sum;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_LOW;
      else       state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      if (win_close) begin
        case (state)
          ST_LOW:  if (avg >= HI_V) state_nxt = ST_HIGH;
          ST_HIGH: if (avg <= LO_V) state_nxt = ST_LOW;
          default: state_nxt = ST_LOW;
        endcase
      end
    end

    assign level[c*LVL_W +: LVL_W] = lvl_q;
    assign alarm[c]                = (state == ST_HIGH);

`ifdef ACTMON_PEAK_HOLD_EN
    logic [LVL_W-1:0] pk;

    // A clear coinciding with a window close reloads from the new average.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pk <= '0;
      end else if (win_close) begin
        pk <= (peak_clear || (avg > pk)) ? avg : pk;
      end else if (peak_clear) begin
        pk <= '0;
      end
    end

    assign peak[c*LVL_W +: LVL_W] = pk;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_activity_monitor_mc.sv
// ============================================================================
// tb_activity_monitor_mc: directed scoreboard bench for activity_monitor_mc.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_activity_monitor_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [63:0] activity;
  logic [31:0] level;
  logic        level_valid;
  logic [3:0]  alarm;
  logic [1:0]  win_count;
`ifdef ACTMON_PEAK_HOLD_EN
  logic        peak_clear;
  logic [31:0] peak;
`endif

  always #5 clk = ~clk;

  activity_monitor_mc dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .activity     (activity),
`ifdef ACTMON_PEAK_HOLD_EN
    .peak_clear   (peak_clear),
    .peak         (peak),
`endif
    .level        (level),
    .level_valid  (level_valid),
    .alarm        (alarm),
    .win_count    (win_count)
  );

  typedef struct packed {
    logic [31:0] lvl;
    logic [3:0]  alm;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [63:0] act);
    exp_t e;
    @(negedge clk);
    sample_valid = v;
    activity     = act;
    @(posedge clk);
    #1;
    check("level_valid", {63'd0, level_valid}, {63'd0, (sb.size() != 0)});
    if (level_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check("level", {32'd0, level}, {32'd0, e.lvl});
      check("alarm", {60'd0, alarm}, {60'd0, e.alm});
    end
  endtask

  task automatic push_exp(input logic [31:0] lvl, input logic [3:0] alm);
    exp_t e;
    e = {lvl, alm};
    sb.push_back(e);
  endtask

  // Four identical valid samples; the expectation is queued with the last one.
  task automatic window(input logic [63:0] act, input logic [31:0] lvl, input logic [3:0] alm);
    repeat (3) step(1'b1, act);
    push_exp(lvl, alm);
    step(1'b1, act);
  endtask

  localparam logic [63:0] TV  = 64'h0000_FF12_01AB_0034;
  localparam logic [63:0] TV0 = 64'h0000_FF12_00AB_0034;
  localparam logic [63:0] GB  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    activity     = '0;
`ifdef ACTMON_PEAK_HOLD_EN
    peak_clear   = 1'b0;
`endif
    #1;
    check("rst_level",       {32'd0, level},       64'd0);
    check("rst_level_valid", {63'd0, level_valid}, 64'd0);
    check("rst_alarm",       {60'd0, alarm},       64'd0);
    check("rst_win_count",   {62'd0, win_count},   64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Alarm set, hold above LO_TH, clear at LO_TH; windows back-to-back.
    window(64'h0000_0000_0000_C000, 32'h0000_00C0, 4'b0001);
    step(1'b0, GB);
    window(64'h0000_0000_0000_8000, 32'h0000_0080, 4'b0001);
    window(64'h0000_0000_0000_4000, 32'h0000_0040, 4'b0000);
    check("wc_start", {62'd0, win_count}, 64'd0);

    // Gapped valid: invalid cycles must neither count nor accumulate.
    step(1'b1, TV);  check("wc_1", {62'd0, win_count}, 64'd1);
    step(1'b0, GB);  check("wc_2", {62'd0, win_count}, 64'd1);
    check("level_hold", {32'd0, level}, 64'h40);
    step(1'b0, GB);  check("wc_3", {62'd0, win_count}, 64'd1);
    step(1'b1, TV);  check("wc_4", {62'd0, win_count}, 64'd2);
    step(1'b0, GB);  check("wc_5", {62'd0, win_count}, 64'd2);
    step(1'b1, TV);  check("wc_6", {62'd0, win_count}, 64'd3);
    push_exp(32'h00FF_0000, 4'b0100);
    step(1'b1, TV0); check("wc_7", {62'd0, win_count}, 64'd0);

    // Asynchronous reset in the middle of a partial window.
    step(1'b1, 64'h0000_0000_0000_FF00);
    step(1'b1, 64'h0000_0000_0000_FF00);
    check("wc_partial", {62'd0, win_count}, 64'd2);
    @(negedge clk);
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_level",       {32'd0, level},       64'd0);
    check("arst_alarm",       {60'd0, alarm},       64'd0);
    check("arst_win_count",   {62'd0, win_count},   64'd0);
    check("arst_level_valid", {63'd0, level_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    window(64'h0000_0000_0000_8000, 32'h0000_0080, 4'b0000);

`ifdef ACTMON_PEAK_HOLD_EN
    check("peak_80", {32'd0, peak}, 64'h80);
    window(64'h0000_0000_0000_5000, 32'h0000_0050, 4'b0000);
    window(64'h0000_0000_0000_A000, 32'h0000_00A0, 4'b0000);
    window(64'h0000_0000_0000_3000, 32'h0000_0030, 4'b0000);
    check("peak_A0", {32'd0, peak}, 64'hA0);
    repeat (3) step(1'b1, 64'h0000_0000_0000_2000);
    push_exp(32'h0000_0020, 4'b0000);
    peak_clear = 1'b1;
    step(1'b1, 64'h0000_0000_0000_2000);
    peak_clear = 1'b0;
    check("peak_clr_close", {32'd0, peak}, 64'h20);
    peak_clear = 1'b1;
    step(1'b0, GB);
    peak_clear = 1'b0;
    check("peak_clr", {32'd0, peak}, 64'h0);
`endif

    step(1'b0, GB);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
